// File: rtl/ksneq_pkg.sv
// Shared types and the key-word expansion helper for the key-schedule
// "no-equal-words" block.
package ksneq_pkg;

   typedef enum logic [1:0] {
      MIN  = 2'd0,
      FAST = 2'd1,
      FULL = 2'd2
   } kwidth_e;

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      PERMUTE,
      CHECK
   } state_e;

   localparam int EXP_MAX = 1024;
   localparam int EXP_AW  = $clog2(EXP_MAX);

   // Output word i takes key word (i mod kwords); bits beyond cwords words are zero.
   function automatic logic [EXP_MAX-1:0] word_expand(input logic [EXP_MAX-1:0] key,
                                                       input int cwords,
                                                       input int kwords,
                                                       input int wordw = 32);
      logic [EXP_MAX-1:0] r;
      r = '0;
      for (int b = 0; b < EXP_MAX; b++) begin
         if (b < cwords * wordw)
            r[EXP_AW'(b)] = key[EXP_AW'(((b / wordw) % kwords) * wordw + (b % wordw))];
      end
      return r;
   endfunction

endpackage

// File: rtl/ksneq_pair_scan.sv
// Walks the (i, j) word-pair sequence over the X region of C, one pair per
// cycle, and flags equality of the selected words.
module ksneq_pair_scan #(
   parameter int XWORDS = 4,
   parameter int WORDW  = 32
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         init,
   input  logic                         step,
   input  logic [(XWORDS+1)*WORDW-1:0]  words,
   output logic                         match,
   output logic                         last
);

   localparam int IW = $clog2(XWORDS + 1) + 1;

   logic [IW-1:0]    i_q, i_d, j_q, j_d;
   logic [WORDW-1:0] wi, wj;

   always_comb begin
      i_d = i_q;
      j_d = j_q;
      if (init) begin
         i_d = '0;
         j_d = IW'(1);
      end else if (step) begin
         // Row wrap happens in the same cycle so the scan has no bubble.
         if (j_q == IW'(XWORDS)) begin
            i_d = i_q + 1'b1;
            j_d = i_q + IW'(2);
         end else begin
            j_d = j_q + 1'b1;
         end
      end
   end

   always_comb begin
      wi = '0;
      wj = '0;
      for (int n = 0; n <= XWORDS; n++) begin
         if (i_q == IW'(n)) wi = words[n*WORDW +: WORDW];
         if (j_q == IW'(n)) wj = words[n*WORDW +: WORDW];
      end
   end

   assign match = (wi == wj);
   assign last  = (i_q == IW'(XWORDS - 1)) && (j_q == IW'(XWORDS));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         i_q <= '0;
         j_q <= '0;
      end else begin
         i_q <= i_d;
         j_q <= j_d;
      end
   end

endmodule

// File: rtl/ksneq_param.sv
// Derives DryGASCON C and X from key K, permuting through a borrowed Gascon
// round core until the X-region words are all distinct.
//
// state   | meaning
// IDLE    | waiting for start; cout/xout/err hold the last job
// EXPAND  | build C (and X for FULL/FAST) from the latched key
// PERMUTE | perm_req high, waiting for the round core's ack
// CHECK   | scan X-region word pairs, one per cycle, for a duplicate
module ksneq_param
   import ksneq_pkg::*;
#(
   parameter int KWIDTHMAX  = 448,
   parameter int MINWIDTH_K = 128,
   parameter int CWIDTH     = 320,
   parameter int XWIDTH     = 128,
   parameter int WORDW      = 32,
   parameter int MAX_PERM   = 255
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [KWIDTHMAX-1:0] k,
   input  logic [1:0]           kWidth,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [CWIDTH-1:0]    cout,
   output logic [XWIDTH-1:0]    xout,
   output logic                 perm_req,
   output logic [CWIDTH-1:0]    perm_cin,
   input  logic [CWIDTH-1:0]    perm_cout,
   input  logic                 perm_ack
);

   localparam int XWORDS = XWIDTH / WORDW;
   localparam int KWORDS = MINWIDTH_K / WORDW;
   localparam int CWORDS = CWIDTH / WORDW;
   localparam int RW     = $clog2(MAX_PERM + 1);

   state_e                 state_q, state_d;
   logic [KWIDTHMAX-1:0]   k_q, k_d;
   logic [1:0]             mode_q, mode_d;
   logic [CWIDTH-1:0]      c_q, c_d, cout_q, cout_d, c_exp;
   logic [XWIDTH-1:0]      x_q, x_d, xout_q, xout_d;
   logic [RW-1:0]          retry_q, retry_d;
   logic                   busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic                   finish, scan_init, scan_step, scan_match, scan_last;

   assign c_exp = CWIDTH'(word_expand(EXP_MAX'(k_q), CWORDS, KWORDS, WORDW));

   ksneq_pair_scan #(
      .XWORDS (XWORDS),
      .WORDW  (WORDW)
   ) u_scan (
      .clk     (clk),
      .reset_n (reset_n),
      .init    (scan_init),
      .step    (scan_step),
      .words   (c_q[(XWORDS+1)*WORDW-1:0]),
      .match   (scan_match),
      .last    (scan_last)
   );

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      mode_d    = mode_q;
      c_d       = c_q;
      x_d       = x_q;
      retry_d   = retry_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = err_q;
      cout_d    = cout_q;
      xout_d    = xout_q;
      finish    = 1'b0;
      scan_init = 1'b0;
      scan_step = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               k_d     = k;
               mode_d  = kWidth;
               busy_d  = 1'b1;
               err_d   = 1'b0;
               retry_d = '0;
               state_d = EXPAND;
            end
         end
         EXPAND: begin
            case (mode_q)
               FULL: begin
                  c_d    = k_q[CWIDTH-1:0];
                  x_d    = k_q[CWIDTH+XWIDTH-1:CWIDTH];
                  finish = 1'b1;
               end
               FAST: begin
                  c_d    = c_exp;
                  x_d    = k_q[MINWIDTH_K+XWIDTH-1:MINWIDTH_K];
                  finish = 1'b1;
               end
               MIN: begin
                  c_d     = c_exp;
                  state_d = PERMUTE;
               end
               default: begin
                  err_d  = 1'b1;
                  finish = 1'b1;
               end
            endcase
         end
         PERMUTE: begin
            if (perm_ack) begin
               c_d       = perm_cout;
               retry_d   = retry_q + 1'b1;
               scan_init = 1'b1;
               state_d   = CHECK;
            end
         end
         CHECK: begin
            if (scan_match) begin
               if (retry_q < RW'(MAX_PERM)) begin
                  state_d = PERMUTE;
               end else begin
                  err_d  = 1'b1;
                  finish = 1'b1;
               end
            end else if (scan_last) begin
               x_d    = c_q[XWIDTH-1:0];
               c_d    = {c_q[CWIDTH-1:XWIDTH], k_q[XWIDTH-1:0]};
               finish = 1'b1;
            end else begin
               scan_step = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs publish the values being written this same edge.
      if (finish) begin
         cout_d  = c_d;
         xout_d  = x_d;
         done_d  = 1'b1;
         busy_d  = 1'b0;
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         mode_q  <= '0;
         c_q     <= '0;
         x_q     <= '0;
         retry_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cout_q  <= '0;
         xout_q  <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         mode_q  <= mode_d;
         c_q     <= c_d;
         x_q     <= x_d;
         retry_q <= retry_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         cout_q  <= cout_d;
         xout_q  <= xout_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign cout     = cout_q;
   assign xout     = xout_q;
   assign perm_req = (state_q == PERMUTE);
   assign perm_cin = c_q;

endmodule

// File: tb/tb_ksneq_param.sv
// Directed and randomized checks of ksneq_param against a word-level
// reference model, with a stub Gascon core answering perm requests.
module tb_ksneq_param;

   localparam int KW  = 448;
   localparam int CW  = 320;
   localparam int XW  = 128;
   localparam int XWD = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n, start, start4;
   logic [KW-1:0] k;
   logic [1:0]    kWidth;
   logic          busy, done, err, perm_req;
   logic          perm_ack = 1'b0;
   logic [CW-1:0] cout, perm_cin;
   logic [CW-1:0] perm_cout = '0;
   logic [XW-1:0] xout;
   logic          busy4, done4, err4, perm_req4, perm_ack4;
   logic [CW-1:0] cout4, perm_cin4, perm_cout4;
   logic [XW-1:0] xout4;

   ksneq_param dut (
      .clk(clk), .reset_n(reset_n), .start(start), .k(k), .kWidth(kWidth),
      .busy(busy), .done(done), .err(err), .cout(cout), .xout(xout),
      .perm_req(perm_req), .perm_cin(perm_cin), .perm_cout(perm_cout), .perm_ack(perm_ack)
   );

   ksneq_param #(.MAX_PERM(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .start(start4), .k(k), .kWidth(kWidth),
      .busy(busy4), .done(done4), .err(err4), .cout(cout4), .xout(xout4),
      .perm_req(perm_req4), .perm_cin(perm_cin4), .perm_cout(perm_cout4), .perm_ack(perm_ack4)
   );

   // Identity round core that acks in the same cycle it is asked.
   assign perm_cout4 = perm_cin4;
   assign perm_ack4  = perm_req4;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Stub round core: acks in the ack_delay-th cycle of each request episode.
   int            stub_mode = 0;
   int            ack_delay = 3;
   int            req_cnt   = 0;
   int            episodes  = 0;
   logic          prev_req  = 1'b0;
   logic [CW-1:0] ret_q[$];

   function automatic logic [CW-1:0] stub_val(input int call);
      logic [CW-1:0] v;
      for (int w = 0; w < 10; w++) begin
         case (stub_mode)
            0:       v[w*32 +: 32] = 32'h1000_0000 + 32'(w);
            1:       v[w*32 +: 32] = (call <= 2) ? 32'hEEEE_0000 + 32'(call) : 32'h1000_0000 + 32'(w);
            default: v[w*32 +: 32] = (w <= XWD) ? 32'hC0DE_0000 + $urandom_range(0, 7) : $urandom();
         endcase
      end
      return v;
   endfunction

   always @(negedge clk) begin
      perm_ack = 1'b0;
      if (perm_req && !prev_req) episodes++;
      prev_req = perm_req;
      if (perm_req) begin
         req_cnt++;
         if (req_cnt == ack_delay) begin
            perm_cout = stub_val(ret_q.size() + 1);
            ret_q.push_back(perm_cout);
            perm_ack = 1'b1;
            req_cnt  = 0;
         end
      end else begin
         req_cnt = 0;
      end
   end

   // Reference model state: the block's internal C and X.
   logic [CW-1:0] m_c = '0;
   logic [XW-1:0] m_x = '0;

   function automatic logic [CW-1:0] expand(input logic [KW-1:0] key);
      logic [CW-1:0] r;
      for (int w = 0; w < 10; w++) r[w*32 +: 32] = key[(w % 4)*32 +: 32];
      return r;
   endfunction

   task automatic model_job(input logic [1:0] mode, input logic [KW-1:0] key, input int maxp,
                            input int delay, output logic e_err, output int e_lat, output int e_calls);
      bit fin, found;
      int cnt;
      e_err = 1'b0; e_lat = 2; e_calls = 0;
      case (mode)
         2'd2: begin m_c = key[CW-1:0]; m_x = key[CW+XW-1:CW]; end
         2'd1: begin m_c = expand(key); m_x = key[255:128]; end
         2'd0: begin
            m_c = expand(key);
            fin = 0;
            for (int n = 1; n <= maxp && !fin; n++) begin
               e_calls = n;
               if (n > ret_q.size()) begin
                  e_calls = -1;
                  fin = 1;
               end else begin
                  m_c = ret_q[n-1];
                  e_lat += delay;
                  found = 0; cnt = 0;
                  for (int i = 0; i < XWD; i++)
                     for (int j = i + 1; j <= XWD; j++)
                        if (!found) begin
                           cnt++;
                           if (m_c[i*32 +: 32] == m_c[j*32 +: 32]) found = 1;
                        end
                  e_lat += cnt;
                  if (!found) begin
                     m_x = m_c[XW-1:0];
                     m_c[XW-1:0] = key[XW-1:0];
                     fin = 1;
                  end else if (n == maxp) begin
                     e_err = 1'b1;
                  end
               end
            end
         end
         default: e_err = 1'b1;
      endcase
   endtask

   task automatic run_job(input string tag, input logic [1:0] mode, input logic [KW-1:0] key,
                          input int delay, input int smode, input bit poke);
      int   cyc, e_lat, e_calls;
      bit   got;
      logic e_err;
      @(negedge clk);
      stub_mode = smode; ack_delay = delay; ret_q.delete(); episodes = 0;
      k = key; kWidth = mode; start = 1'b1;
      cyc = 0; got = 0;
      for (int t = 0; t < 3000 && !got; t++) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (poke && cyc == 3) begin
            start = 1'b1; kWidth = 2'd2; k = ~key;
         end
         if (cyc == 1) chk({tag, "_busy"}, busy, 1);
         if (done) got = 1;
      end
      start = 1'b0;
      chk({tag, "_done_seen"}, got, 1);
      model_job(mode, key, 255, delay, e_err, e_lat, e_calls);
      chk({tag, "_cout"}, cout, m_c);
      chk({tag, "_xout"}, xout, m_x);
      chk({tag, "_err"}, err, e_err);
      chk({tag, "_latency"}, cyc, e_lat);
      chk({tag, "_busy_end"}, busy, 0);
      chk({tag, "_perm_calls"}, episodes, (mode == 2'd0) ? e_calls : 0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [KW-1:0] key;
      int            ep4, cyc;
      bit            got, prev4, saw_done;

      reset_n = 1'b1; start = 1'b0; start4 = 1'b0; k = '0; kWidth = 2'd0;
      #2 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_ctrl", {busy, done, err, perm_req}, 0);
      chk("reset_cout", cout, 0);
      chk("reset_xout", xout, 0);
      reset_n = 1'b1;

      // Retry exhaustion on the MAX_PERM=4 instance, then a FULL job clears err.
      for (int w = 0; w < 14; w++) key[w*32 +: 32] = $urandom();
      @(negedge clk);
      k = key; kWidth = 2'd0; start4 = 1'b1;
      ep4 = 0; prev4 = 0; got = 0;
      for (int t = 0; t < 500 && !got; t++) begin
         @(negedge clk);
         start4 = 1'b0;
         if (perm_req4 && !prev4) ep4++;
         prev4 = perm_req4;
         if (done4) got = 1;
      end
      chk("exh_done_seen", got, 1);
      chk("exh_err", err4, 1);
      chk("exh_perm_calls", ep4, 4);
      chk("exh_cout", cout4, expand(key));
      chk("exh_xout", xout4, 0);
      @(negedge clk);
      kWidth = 2'd2; start4 = 1'b1; got = 0;
      for (int t = 0; t < 50 && !got; t++) begin
         @(negedge clk);
         start4 = 1'b0;
         if (done4) got = 1;
      end
      chk("exh_clear_done", got, 1);
      chk("exh_clear_err", err4, 0);
      chk("exh_clear_cout", cout4, key[CW-1:0]);
      chk("exh_clear_xout", xout4, key[CW+XW-1:CW]);

      for (int b = 0; b < 56; b++) key[b*8 +: 8] = 8'(b);
      run_job("full", 2'd2, key, 3, 0, 0);
      chk("full_cout_const", cout, key[CW-1:0]);

      key = '0;
      key[127:0]   = 128'h33333333_22222222_11111111_00000000;
      key[255:128] = {4{32'hAAAA_AAAA}};
      run_job("fast", 2'd1, key, 3, 0, 0);
      chk("fast_xout_const", xout, {4{32'hAAAA_AAAA}});

      for (int w = 0; w < 14; w++) key[w*32 +: 32] = $urandom();
      run_job("min_clean", 2'd0, key, 3, 0, 0);
      chk("min_clean_xout_const", xout, 128'h10000003_10000002_10000001_10000000);
      chk("min_clean_ckey", cout[127:0], key[127:0]);

      run_job("min_retry", 2'd0, key, 1, 1, 0);
      chk("min_retry_calls_const", episodes, 3);

      run_job("illegal", 2'd3, key, 3, 0, 0);
      chk("illegal_err_const", err, 1);

      run_job("start_busy", 2'd0, key, 3, 0, 1);

      for (int r = 0; r < 8; r++) begin
         for (int w = 0; w < 14; w++) key[w*32 +: 32] = $urandom();
         run_job("rand", 2'($urandom_range(0, 3)), key, $urandom_range(1, 4), 2, 0);
      end

      // Reset in the middle of a permutation wait.
      @(negedge clk);
      stub_mode = 0; ack_delay = 1000;
      k = key; kWidth = 2'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_in_permute", perm_req, 1);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_ctrl", {busy, done, err, perm_req}, 0);
      chk("rst_mid_cout", cout, 0);
      chk("rst_mid_xout", xout, 0);
      chk("rst_mid_cin", perm_cin, 0);
      saw_done = 0;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         if (done) saw_done = 1;
      end
      chk("rst_no_done", saw_done, 0);
      reset_n = 1'b1;
      m_c = '0; m_x = '0;
      run_job("after_rst", 2'd1, key, 3, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ksneq_param.md
Name: ksneq_param

Overview:
- Parametrised successor to the fixed-width key-schedule "no-equal-words" block.
- Derives the DryGASCON state C and the X key from a variable-width key K in three modes: FULL (direct load), FAST (key-word expansion), MIN (expansion, then permute until the X-region words are unique).
- New relative to the previous generation: word width, C/X sizes and retry limit are all parameters. Uniqueness scan exits early on the first match. A retry limit raises an error flag.
- Re-startable start/busy/done handshake.
- Borrows the shared Gascon round core through a req/ack port pair instead of instantiating its own.

Parameters:
- KWIDTHMAX, 448, width of key input port
- MINWIDTH_K, 128, key width in MIN/FAST modes; multiple of WORDW
- CWIDTH, 320, C state width; multiple of WORDW
- XWIDTH, 128, X width; XWIDTH+WORDW <= CWIDTH
- WORDW, 32, comparison/expansion word width
- MAX_PERM, 255, max permutation calls per job before error

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  job request, sampled only in IDLE
- k  in  KWIDTHMAX  key
- kWidth  in  2  mode: 0 MIN, 1 FAST, 2 FULL, 3 illegal
- busy  out  1  job in progress
- done  out  1  one-cycle pulse, job finished (ok or error)
- err  out  1  level, last job failed; cleared on next accepted start
- cout  out  CWIDTH  derived C
- xout  out  XWIDTH  derived X
- perm_req  out  1  request one Gascon round on perm_cin
- perm_cin  out  CWIDTH  state to permute (= current C)
- perm_cout  in  CWIDTH  permuted state
- perm_ack  in  1  perm_cout valid; single-cycle pulse

Behaviour:
- Reset (async, reset_n=0): state IDLE; busy, done, err, perm_req = 0; cout, xout, internal C/X/K, counters = 0. Reset mid-job aborts with no done pulse.
- Derived constants: XWORDS = XWIDTH/WORDW; KWORDS = MINWIDTH_K/WORDW; CWORDS = CWIDTH/WORDW; NPAIRS = XWORDS*(XWORDS+1)/2.
- IDLE: on start=1:
  - latch k and kWidth; busy<=1; err<=0; retry counter<=0; go EXPAND.
  - start while busy is ignored.
- EXPAND (1 cycle):
  - FULL: C=k[CWIDTH-1:0], X=k[CWIDTH+XWIDTH-1:CWIDTH]; finish.
  - FAST: C word i = k word (i mod KWORDS) for i<CWORDS; X=k[MINWIDTH_K+XWIDTH-1:MINWIDTH_K]; finish.
  - MIN: C expanded as in FAST; go PERMUTE.
  - Illegal mode (3): err<=1; finish.
- PERMUTE:
  - perm_req=1 while in this state; perm_cin=C.
  - On perm_ack: C<=perm_cout; retry counter +1; pair indices i<=0, j<=1; go CHECK.
  - perm_ack outside PERMUTE is ignored.
- CHECK: one pair per cycle, i in 0..XWORDS-1, j in i+1..XWORDS, compare C word i vs C word j.
  - Equal pair: stop the scan immediately.
    - retry counter < MAX_PERM: go PERMUTE.
    - retry counter = MAX_PERM: err<=1; finish.
  - j=XWORDS with i<XWORDS-1: i<=i+1, j<=i+2, same cycle, no bubble.
  - Last pair (i=XWORDS-1, j=XWORDS) unequal:
    - X=C[XWIDTH-1:0];
    - C[XWIDTH-1:0]=k[XWIDTH-1:0], upper C bits unchanged;
    - finish.
- finish (same edge): cout<=C, xout<=X, done<=1 for one cycle, busy<=0, state IDLE.
- On error: cout/xout still load the current C/X; err stays high until the next accepted start.
- cout/xout hold between jobs.
- Latency, measured from the start-sampling edge:
  - FULL/FAST/illegal: done 2 cycles after start is sampled.
  - MIN: 1 (EXPAND) + sum over permutations of (perm wait + 1) + check cycles. The clean case is NPAIRS check cycles, 10 at defaults.
- perm_ack in the same cycle perm_req first rises is legal.
- Counter widths: i,j $clog2(XWORDS+1)+1; retry counter $clog2(MAX_PERM+1).

Decomposition:
- Package ksneq_pkg:
  - kwidth_e enum (MIN=0, FAST=1, FULL=2);
  - state_e enum (IDLE, EXPAND, PERMUTE, CHECK);
  - function word_expand(key, CWORDS, KWORDS).
- Sub-module ksneq_pair_scan holds the i/j pair counter and comparator, with ports init, step, match, last.

Test Plan:
- FULL: k[447:0]=incrementing bytes 0x00..0x37, kWidth=2 -> done 2 cycles after start; cout=k[319:0], xout=k[447:320]; err=0; perm_req never high.
- FAST: k[127:0]=0x33333333_22222222_11111111_00000000, k[255:128]=0xA...A, kWidth=1 -> cout = words 0,1,2,3 repeated over 10 words; xout=0xAAAA...A (128b); 2-cycle latency.
- MIN clean: stub perm returns word w = 0x1000_0000+w, ack after 3 cycles -> exactly 1 perm_req episode; 10 CHECK cycles.
  - xout=0x10000003_10000002_10000001_10000000.
  - cout[127:0]=k[127:0]; cout[319:128] = stub words 4..9.
  - done at 1+4+10=15 cycles.
- MIN retry: stub returns all-equal words for the first 2 calls, then distinct words -> 3 perm_req episodes. The first mismatch-free scan occurs after call 3; done, err=0.
- Exhaustion: identity stub, MAX_PERM=4 -> 4 perm calls, then done with err=1. A following FULL start clears err.
- Reset/illegal:
  - reset_n low mid-PERMUTE -> all outputs 0 immediately, no done.
  - kWidth=3 -> done+err after 2 cycles.
  - start during busy -> ignored; the job result is unchanged.
